axi_mem_initiator: RTL and testbench
====================================

AXI_MEM_INITIATOR -- requirements
Module: axi_mem_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word address width on both the request side and the bus side.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, handshake wait limit in cycles; used only when AXI_MEM_INITIATOR_TIMEOUT_EN is defined.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 AXI_MEM_INITIATOR_Clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 AXI_MEM_INITIATOR_Reset_n  in  1  asynchronous active-low reset.
REQ-006 AXI_MEM_INITIATOR_Req_Valid  in  1  core request present.
REQ-007 AXI_MEM_INITIATOR_Req_Write  in  1  1 = write, 0 = read.
REQ-008 AXI_MEM_INITIATOR_Req_Address  in  ADDR_WIDTH  word address.
REQ-009 AXI_MEM_INITIATOR_Req_Wdata  in  32  write data.
REQ-010 AXI_MEM_INITIATOR_Req_Ready  out  1  request accepted when high together with Req_Valid.
REQ-011 AXI_MEM_INITIATOR_Rsp_Valid  out  1  one-cycle completion pulse.
REQ-012 AXI_MEM_INITIATOR_Rsp_Rdata  out  32  read data; 0 for writes and errors.
REQ-013 AXI_MEM_INITIATOR_Rsp_Error  out  1  timeout flag, qualified by Rsp_Valid.
REQ-014 AXI_MEM_INITIATOR_Bus_Read_Ready  out  1  read strobe to the RAM.
REQ-015 AXI_MEM_INITIATOR_Bus_Write_Valid  out  1  write strobe to the RAM.
REQ-016 AXI_MEM_INITIATOR_Bus_Address  out  ADDR_WIDTH  RAM address.
REQ-017 AXI_MEM_INITIATOR_Bus_Data_Out  out  32  RAM write data.
REQ-018 AXI_MEM_INITIATOR_Bus_Read_Valid  in  1  RAM read acknowledge.
REQ-019 AXI_MEM_INITIATOR_Bus_Write_Ready  in  1  RAM write acknowledge.
REQ-020 AXI_MEM_INITIATOR_Bus_Data_In  in  32  RAM read data, registered by the RAM and valid the cycle after the read handshake.

Function
REQ-021 SHALL implement the FSM states IDLE, WR, RD_ADDR, RD_DATA and RESP.
REQ-022 SHALL drive Req_Ready high only in IDLE.
REQ-023 On an accepting edge (IDLE, Req_Valid=1), SHALL latch Write, Address and Wdata, then go to WR if Write=1, else to RD_ADDR.
REQ-024 In WR, SHALL hold Bus_Write_Valid=1 with the latched address and data; on an edge with Bus_Write_Ready=1, SHALL go to RESP.
REQ-025 In RD_ADDR, SHALL hold Bus_Read_Ready=1 with the latched address; on an edge with Bus_Read_Valid=1, SHALL go to RD_DATA.
REQ-026 In RD_DATA, SHALL keep Bus_Read_Ready=1, capture Bus_Data_In into Rsp_Rdata at the edge, and go to RESP.
REQ-027 In RESP, SHALL assert Rsp_Valid for exactly one cycle, then go to IDLE.
REQ-028 SHALL hold Rsp_Rdata stable until the next RESP; SHALL force it to 0 for a write.
REQ-029 Latency, with a responder that acknowledges immediately: a write SHALL give Rsp_Valid 2 cycles after the accepting edge; a read, 3 cycles.
REQ-030 SHALL never assert Bus_Read_Ready and Bus_Write_Valid together; both SHALL be 0 in IDLE and RESP.
REQ-031 SHALL drive Bus_Address and Bus_Data_Out from the latched registers only; they SHALL not change while a strobe is high.
REQ-032 SHALL ignore Req_Valid, Req_Write, Req_Address and Req_Wdata outside IDLE.
REQ-033 Back-to-back requests: the next acceptance SHALL occur at the earliest in the first IDLE cycle after RESP.
REQ-034 SHALL ignore a stray Bus_Read_Valid in WR and a stray Bus_Write_Ready in RD_ADDR.

Reset
REQ-035 Reset_n low SHALL force IDLE immediately and clear all outputs and latched registers to 0, aborting any transfer in flight.
REQ-036 Req_Ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-037 With AXI_MEM_INITIATOR_TIMEOUT_EN defined, a counter SHALL count cycles spent in WR or RD_ADDR.
REQ-038 With AXI_MEM_INITIATOR_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES without a handshake, the FSM SHALL drop the strobes, go to RESP, and present Rsp_Error=1 with Rsp_Rdata=0.
REQ-039 With AXI_MEM_INITIATOR_TIMEOUT_EN defined, a handshake on the same edge as the limit SHALL win, with no error.
REQ-040 With AXI_MEM_INITIATOR_TIMEOUT_EN defined, the counter SHALL clear on every state entry.
REQ-041 Without AXI_MEM_INITIATOR_TIMEOUT_EN, the block SHALL wait indefinitely, tie Rsp_Error to 0, and contain no counter logic.

Structure
REQ-042 A shared package SHALL hold the FSM state encodings, the data width constant (32), and the default ADDR_WIDTH and TIMEOUT_CYCLES.
REQ-043 The timeout counter SHALL be the sub-module axi_mem_timeout (clear, enable, expired), instantiated only under the macro.

Verification
REQ-044 Reset, then write addr 0x005 data 0xDEADBEEF to a RAM model -> one cycle of Bus_Write_Valid, Rsp_Valid 2 cycles after acceptance, Rsp_Error=0.
REQ-045 Read addr 0x005 -> Rsp_Valid 3 cycles after acceptance, Rsp_Rdata=0xDEADBEEF.
REQ-046 Bus_Write_Ready held low for 4 cycles -> Bus_Write_Valid, Bus_Address and Bus_Data_Out stable for 5 cycles, then a single Rsp_Valid.
REQ-047 Macro defined, TIMEOUT_CYCLES=15, Bus_Read_Valid stuck low -> Rsp_Valid with Rsp_Error=1, Rsp_Rdata=0; Req_Ready returns to 1.
REQ-048 Reset_n pulsed low during RD_DATA -> all outputs 0 asynchronously, no Rsp_Valid; a following read of 0x3FF completes normally.
REQ-049 Back-to-back write 0x3FF=0x1 then read 0x3FF with Req_Valid held high -> second acceptance in the IDLE cycle after RESP; read returns 0x00000001.

Source files
------------

// File: rtl/axi_mem_initiator_pkg.sv
// -----------------------------------------------------------------------------
// axi_mem_initiator_pkg
// Shared definitions for the memory initiator:
//   - DATA_WIDTH             : width of every data path (32)
//   - DEFAULT_ADDR_WIDTH     : default word-address width
//   - DEFAULT_TIMEOUT_CYCLES : default handshake wait limit
//   - state_t                : FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package axi_mem_initiator_pkg;

  localparam int DATA_WIDTH             = 32;
  localparam int DEFAULT_ADDR_WIDTH     = 10;
  localparam int DEFAULT_TIMEOUT_CYCLES = 15;

  // IDLE is encoded as zero so a cleared state register is the idle state.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/axi_mem_initiator_timeout.sv
// -----------------------------------------------------------------------------
// axi_mem_timeout
// Handshake watchdog for axi_mem_initiator. Counts cycles while 'enable' is
// high and flags 'expired' during the LIMIT-th such cycle, so the owner can
// leave its wait state on that edge.
// Only built when AXI_MEM_INITIATOR_TIMEOUT_EN is defined; without the macro
// the initiator waits indefinitely and has no counter at all.
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   clear   in  synchronous counter clear (held while not waiting)
//   enable  in  count this cycle
//   expired out limit reached in the current cycle
// -----------------------------------------------------------------------------
`ifdef AXI_MEM_INITIATOR_TIMEOUT_EN
module axi_mem_timeout
  import axi_mem_initiator_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // 'count' holds the number of waiting cycles already completed, so the
  // limit is hit while count sits at LIMIT-1. It saturates there in case the
  // owner keeps waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(LIMIT - 1))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/axi_mem_initiator.sv
// -----------------------------------------------------------------------------
// axi_mem_initiator
// Turns single-word core requests into strobe/acknowledge transfers on a
// simple RAM bus and returns a one-cycle completion pulse.
// Optional build macro: AXI_MEM_INITIATOR_TIMEOUT_EN adds a handshake
// watchdog (axi_mem_timeout) that ends a stalled transfer with Rsp_Error=1.
// Parameters:
//   ADDR_WIDTH      word-address width (request and bus side)
//   TIMEOUT_CYCLES  handshake wait limit, used only with the macro
// Ports:
//   Clk, Reset_n                clock / async active-low reset
//   Req_Valid/Write/Address/Wdata  core request (in)
//   Req_Ready                   request accepted when high with Req_Valid
//   Rsp_Valid/Rdata/Error       one-cycle completion, read data, timeout flag
//   Bus_Read_Ready/Write_Valid  read / write strobes to the RAM
//   Bus_Address/Data_Out        latched address / write data to the RAM
//   Bus_Read_Valid/Write_Ready  RAM acknowledges
//   Bus_Data_In                 RAM read data, valid the cycle after a read ack
// -----------------------------------------------------------------------------
module axi_mem_initiator
  import axi_mem_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  AXI_MEM_INITIATOR_Clk,
  input  logic                  AXI_MEM_INITIATOR_Reset_n,
  input  logic                  AXI_MEM_INITIATOR_Req_Valid,
  input  logic                  AXI_MEM_INITIATOR_Req_Write,
  input  logic [ADDR_WIDTH-1:0] AXI_MEM_INITIATOR_Req_Address,
  input  logic [DATA_WIDTH-1:0] AXI_MEM_INITIATOR_Req_Wdata,
  output logic                  AXI_MEM_INITIATOR_Req_Ready,
  output logic                  AXI_MEM_INITIATOR_Rsp_Valid,
  output logic [DATA_WIDTH-1:0] AXI_MEM_INITIATOR_Rsp_Rdata,
  output logic                  AXI_MEM_INITIATOR_Rsp_Error,
  output logic                  AXI_MEM_INITIATOR_Bus_Read_Ready,
  output logic                  AXI_MEM_INITIATOR_Bus_Write_Valid,
  output logic [ADDR_WIDTH-1:0] AXI_MEM_INITIATOR_Bus_Address,
  output logic [DATA_WIDTH-1:0] AXI_MEM_INITIATOR_Bus_Data_Out,
  input  logic                  AXI_MEM_INITIATOR_Bus_Read_Valid,
  input  logic                  AXI_MEM_INITIATOR_Bus_Write_Ready,
  input  logic [DATA_WIDTH-1:0] AXI_MEM_INITIATOR_Bus_Data_In
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rd_strobe_q;
  logic                  wr_strobe_q;
  logic                  rsp_valid_q;
  logic                  rsp_error_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  timeout_hit;

`ifdef AXI_MEM_INITIATOR_TIMEOUT_EN
  logic waiting;

  // Only WR and RD_ADDR wait on the RAM. Both are entered from IDLE, and the
  // counter is held clear in every other state, so each entry starts at zero.
  assign waiting = (state == WR) || (state == RD_ADDR);

  axi_mem_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (AXI_MEM_INITIATOR_Clk),
    .rst_n   (AXI_MEM_INITIATOR_Reset_n),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (timeout_hit)
  );
`else
  // No watchdog: transfers wait for the RAM indefinitely and the error flag
  // stays constant zero. The parameter only keeps both builds interchangeable.
  assign timeout_hit = 1'b0 & TIMEOUT_CYCLES[0];
`endif

  // Single registered FSM. Strobes, response and latched request fields are
  // all updated here so every output comes straight from a flop. An
  // acknowledge is checked before the timeout so a handshake on the limit
  // edge completes normally. Acks that do not belong to the current state
  // (read ack in WR, write ack in RD_ADDR) are simply not looked at.
  always_ff @(posedge AXI_MEM_INITIATOR_Clk or negedge AXI_MEM_INITIATOR_Reset_n) begin
    if (!AXI_MEM_INITIATOR_Reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_strobe_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (AXI_MEM_INITIATOR_Req_Valid) begin
            addr_q  <= AXI_MEM_INITIATOR_Req_Address;
            wdata_q <= AXI_MEM_INITIATOR_Req_Wdata;
            if (AXI_MEM_INITIATOR_Req_Write) begin
              wr_strobe_q <= 1'b1;
              state       <= WR;
            end else begin
              rd_strobe_q <= 1'b1;
              state       <= RD_ADDR;
            end
          end
        end
        WR: begin
          if (AXI_MEM_INITIATOR_Bus_Write_Ready || timeout_hit) begin
            wr_strobe_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= !AXI_MEM_INITIATOR_Bus_Write_Ready;
            rsp_rdata_q <= '0;
            state       <= RESP;
          end
        end
        RD_ADDR: begin
          if (AXI_MEM_INITIATOR_Bus_Read_Valid) begin
            state <= RD_DATA;
          end else if (timeout_hit) begin
            rd_strobe_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_rdata_q <= '0;
            state       <= RESP;
          end
        end
        RD_DATA: begin
          rd_strobe_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= AXI_MEM_INITIATOR_Bus_Data_In;
          state       <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Ready is gated by the reset pin so it reads 0 while reset is held and 1
  // immediately after release, without waiting for a clock edge.
  assign AXI_MEM_INITIATOR_Req_Ready       = (state == IDLE) && AXI_MEM_INITIATOR_Reset_n;
  assign AXI_MEM_INITIATOR_Rsp_Valid       = rsp_valid_q;
  assign AXI_MEM_INITIATOR_Rsp_Rdata       = rsp_rdata_q;
  assign AXI_MEM_INITIATOR_Rsp_Error       = rsp_error_q;
  assign AXI_MEM_INITIATOR_Bus_Read_Ready  = rd_strobe_q;
  assign AXI_MEM_INITIATOR_Bus_Write_Valid = wr_strobe_q;
  assign AXI_MEM_INITIATOR_Bus_Address     = addr_q;
  assign AXI_MEM_INITIATOR_Bus_Data_Out    = wdata_q;

endmodule

// File: tb/tb_axi_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_initiator
// Self-checking bench for axi_mem_initiator: directed vector table, hand
// sequences for back-to-back, reset abort and stalled reads, then random
// transactions checked against a word-array memory model and latency rule.
// -----------------------------------------------------------------------------
module tb_axi_mem_initiator;

  localparam int AW = 10;
  localparam int TO = 15;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_address;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic          bus_read_ready;
  logic          bus_write_valid;
  logic [AW-1:0] bus_address;
  logic [31:0]   bus_data_out;
  logic          bus_read_valid;
  logic          bus_write_ready;
  logic [31:0]   bus_data_in = '0;

  int vec_count  = 0;
  int miss_count = 0;

  axi_mem_initiator #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .AXI_MEM_INITIATOR_Clk             (clk),
    .AXI_MEM_INITIATOR_Reset_n         (rst_n),
    .AXI_MEM_INITIATOR_Req_Valid       (req_valid),
    .AXI_MEM_INITIATOR_Req_Write       (req_write),
    .AXI_MEM_INITIATOR_Req_Address     (req_address),
    .AXI_MEM_INITIATOR_Req_Wdata       (req_wdata),
    .AXI_MEM_INITIATOR_Req_Ready       (req_ready),
    .AXI_MEM_INITIATOR_Rsp_Valid       (rsp_valid),
    .AXI_MEM_INITIATOR_Rsp_Rdata       (rsp_rdata),
    .AXI_MEM_INITIATOR_Rsp_Error       (rsp_error),
    .AXI_MEM_INITIATOR_Bus_Read_Ready  (bus_read_ready),
    .AXI_MEM_INITIATOR_Bus_Write_Valid (bus_write_valid),
    .AXI_MEM_INITIATOR_Bus_Address     (bus_address),
    .AXI_MEM_INITIATOR_Bus_Data_Out    (bus_data_out),
    .AXI_MEM_INITIATOR_Bus_Read_Valid  (bus_read_valid),
    .AXI_MEM_INITIATOR_Bus_Write_Ready (bus_write_ready),
    .AXI_MEM_INITIATOR_Bus_Data_In     (bus_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM responder: acknowledges once a strobe has waited 'stall' cycles;
  // with stall 0 the ack is always high, including stray acks in other states.
  logic [31:0] ram [0:1023] = '{default: 32'h0};
  int wr_stall = 0;
  int rd_stall = 0;
  int wr_wait  = 0;
  int rd_wait  = 0;

  assign bus_write_ready = (wr_wait >= wr_stall);
  assign bus_read_valid  = (rd_wait >= rd_stall);

  always @(posedge clk) begin
    if (bus_write_valid && bus_write_ready) ram[bus_address] <= bus_data_out;
    if (bus_read_ready && bus_read_valid) bus_data_in <= ram[bus_address];
    if (bus_write_valid && !bus_write_ready) wr_wait <= wr_wait + 1;
    else wr_wait <= 0;
    if (bus_read_ready && !bus_read_valid) rd_wait <= rd_wait + 1;
    else rd_wait <= 0;
  end

  // Reference memory: what each word should hold after the requests so far.
  logic [31:0] model_mem [0:1023] = '{default: 32'h0};

  // Bus-protocol watchers, summarised at the end of the run.
  int            strobe_clash  = 0;
  int            strobe_drift  = 0;
  int            rsp_stretch   = 0;
  logic          prev_strobe   = 1'b0;
  logic          prev_rsp      = 1'b0;
  logic [AW-1:0] prev_addr     = '0;
  logic [31:0]   prev_data     = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_read_ready && bus_write_valid) strobe_clash++;
      if ((req_ready || rsp_valid) && (bus_read_ready || bus_write_valid)) strobe_clash++;
      if (prev_strobe && (bus_read_ready || bus_write_valid) &&
          ((bus_address !== prev_addr) || (bus_data_out !== prev_data))) strobe_drift++;
      if (prev_rsp && rsp_valid) rsp_stretch++;
      prev_strobe = bus_read_ready || bus_write_valid;
      prev_rsp    = rsp_valid;
      prev_addr   = bus_address;
      prev_data   = bus_data_out;
    end else begin
      prev_strobe = 1'b0;
      prev_rsp    = 1'b0;
    end
  end

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present a request from a negedge, wait for acceptance, then scramble the
  // request inputs (including valid) while the transfer is in flight.
  // Returns at the negedge of the first cycle after the accepting edge.
  task automatic applyStimulus(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    int waited;
    req_valid   = 1'b1;
    req_write   = w;
    req_address = a;
    req_wdata   = d;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) checkOutput("accept_wait_expired", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid   = 1'($urandom_range(0, 1));
    req_write   = 1'($urandom_range(0, 1));
    req_address = AW'($urandom);
    req_wdata   = $urandom;
  endtask

  // Starting in cycle 1 after acceptance, find the completion pulse.
  task automatic waitResponse(output int lat, output logic [31:0] rdata,
                              output logic err, output int wr_cycles);
    bit got;
    got = 1'b0;
    lat = 0;
    rdata = '0;
    err = 1'b0;
    wr_cycles = 0;
    for (int n = 1; n <= 100 && !got; n++) begin
      if (n > 1) @(negedge clk);
      if (bus_write_valid) wr_cycles++;
      if (rsp_valid) begin
        got   = 1'b1;
        lat   = n;
        rdata = rsp_rdata;
        err   = rsp_error;
      end
    end
    req_valid = 1'b0;
    if (!got) checkOutput("response_wait_expired", 32'(rsp_valid), 32'd1);
  endtask

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            wr_stall;
    int            rd_stall;
    int            exp_lat;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    int            exp_wr_cycles;
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    int          lat;
    int          wrc;
    int          cnt;
    logic [31:0] rd;
    logic        er;
    logic        w;
    logic [AW-1:0] a;
    logic [31:0] d;

    vecs[0] = '{1'b1, 10'h005, 32'hDEADBEEF, 0, 0, 2, 32'h0,        1'b0, 1};
    vecs[1] = '{1'b0, 10'h005, 32'h0,        0, 0, 3, 32'hDEADBEEF, 1'b0, 0};
    vecs[2] = '{1'b1, 10'h010, 32'h12345678, 4, 0, 6, 32'h0,        1'b0, 5};
    vecs[3] = '{1'b0, 10'h010, 32'h0,        0, 2, 5, 32'h12345678, 1'b0, 0};
    vecs[4] = '{1'b1, 10'h3FF, 32'hCAFEF00D, 1, 0, 3, 32'h0,        1'b0, 2};
    vecs[5] = '{1'b0, 10'h3FF, 32'h0,        0, 1, 4, 32'hCAFEF00D, 1'b0, 0};
    vecs[6] = '{1'b0, 10'h000, 32'h0,        0, 0, 3, 32'h0,        1'b0, 0};

    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_address = '0;
    req_wdata   = '0;
    rst_n       = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs_zero",
                32'({req_ready, rsp_valid, rsp_error, bus_read_ready, bus_write_valid,
                     |bus_address, |bus_data_out, |rsp_rdata}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      wr_stall = vecs[i].wr_stall;
      rd_stall = vecs[i].rd_stall;
      if (vecs[i].write) model_mem[vecs[i].addr] = vecs[i].wdata;
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata);
      waitResponse(lat, rd, er, wrc);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_wr_strobe_cycles", i), 32'(wrc), 32'(vecs[i].exp_wr_cycles));
    end

    // Back-to-back with Req_Valid held: write 0x3FF=1 then read 0x3FF.
    wr_stall = 0;
    rd_stall = 0;
    @(negedge clk);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_address = 10'h3FF;
    req_wdata   = 32'h1;
    model_mem[10'h3FF] = 32'h1;
    cnt = 0;
    while (!req_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b0;
    req_wdata = 32'h55AA55AA;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (rsp_valid) lat = n;
    end
    checkOutput("b2b_write_latency", 32'(lat), 32'd2);
    checkOutput("b2b_ready_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("b2b_ready_after_resp", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    waitResponse(lat, rd, er, wrc);
    checkOutput("b2b_read_latency", 32'(lat), 32'd3);
    checkOutput("b2b_read_rdata", rd, 32'h1);

    // Reset pulse while in RD_DATA aborts the read.
    @(negedge clk);
    applyStimulus(1'b0, 10'h010, 32'hA5A5A5A5);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_rd_data_strobe", 32'(bus_read_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs_zero",
                32'({req_ready, rsp_valid, rsp_error, bus_read_ready, bus_write_valid,
                     |bus_address, |bus_data_out, |rsp_rdata}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_abort", 32'(req_ready), 32'd1);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    checkOutput("abort_no_response", 32'(cnt), 32'd0);
    applyStimulus(1'b0, 10'h3FF, 32'h0);
    waitResponse(lat, rd, er, wrc);
    checkOutput("after_abort_latency", 32'(lat), 32'd3);
    checkOutput("after_abort_rdata", rd, 32'h1);

    // Read acknowledge stuck low.
    @(negedge clk);
    rd_stall = 100000;
`ifdef AXI_MEM_INITIATOR_TIMEOUT_EN
    applyStimulus(1'b0, 10'h005, 32'h0);
    waitResponse(lat, rd, er, wrc);
    checkOutput("timeout_latency", 32'(lat), 32'(TO + 1));
    checkOutput("timeout_error", 32'(er), 32'd1);
    checkOutput("timeout_rdata", rd, 32'h0);
    @(negedge clk);
    checkOutput("timeout_ready_back", 32'(req_ready), 32'd1);
    rd_stall = 0;
`else
    applyStimulus(1'b0, 10'h005, 32'h0);
    cnt = 0;
    repeat (40) begin
      if (rsp_valid) cnt++;
      @(negedge clk);
    end
    checkOutput("stuck_no_response", 32'(cnt), 32'd0);
    checkOutput("stuck_strobe_held", 32'(bus_read_ready), 32'd1);
    rd_stall = 0;
    waitResponse(lat, rd, er, wrc);
    checkOutput("stuck_release_rdata", rd, model_mem[10'h005]);
    checkOutput("stuck_release_error", 32'(er), 32'd0);
`endif

    // Random transactions against the memory model and the latency rule:
    // write completes in cycle 2+wait, read in cycle 3+wait.
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = (i % 5 == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
      d = $urandom;
      wr_stall = $urandom_range(0, 3);
      rd_stall = $urandom_range(0, 3);
      applyStimulus(w, a, d);
      waitResponse(lat, rd, er, wrc);
      checkOutput($sformatf("rnd%0d_latency", i), 32'(lat),
                  32'(w ? 2 + wr_stall : 3 + rd_stall));
      checkOutput($sformatf("rnd%0d_rdata", i), rd, w ? 32'h0 : model_mem[a]);
      checkOutput($sformatf("rnd%0d_error", i), 32'(er), 32'd0);
      checkOutput($sformatf("rnd%0d_wr_strobe_cycles", i), 32'(wrc),
                  32'(w ? wr_stall + 1 : 0));
      if (w) model_mem[a] = d;
    end

    checkOutput("strobe_clash_count", 32'(strobe_clash), 32'd0);
    checkOutput("strobe_drift_count", 32'(strobe_drift), 32'd0);
    checkOutput("rsp_stretch_count", 32'(rsp_stretch), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
